data_sram_bridge: RTL and testbench
===================================

Name: data_sram_bridge

Overview:
- Memory-stage load/store unit between the pipeline's M stage and an SRAM-like data bus (req / addr_ok / data_ok).
- Consumes the M-stage address and store data, and returns load data with sign or zero extension.
- Formats store bytes and checks alignment.
- Asserts stallM while a bus transaction is outstanding, so the hazard unit freezes F/D/E/M.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- memenM  in  1  M-stage instruction is a load or store.
- memwriteM  in  1  1 = store, 0 = load.
- lstypeM  in  3  000 byte-signed, 001 byte-unsigned, 010 half-signed, 011 half-unsigned, 100 word. Stores use 000/010/100.
- aluoutM  in  32  effective address.
- writedataM  in  32  raw store data from rt.
- holdM  in  1  external stall (other units); blocks the pipeline from advancing.
- readdataM  out  32  extended load result; valid in DONE.
- stallM  out  1  freeze request to the hazard unit.
- adelM  out  1  load address misaligned.
- adesM  out  1  store address misaligned.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  bus address, equal to aluoutM.
- data_wstrb  out  4  byte enables.
- data_wdata  out  32  replicated store data.
- data_addr_ok  in  1  bus accepted the request.
- data_data_ok  in  1  bus completed; data_rdata is valid.
- data_rdata  in  32  bus read data.

Behaviour:
- Reset values (async, rst=0): state IDLE, readdataM=0, data_req=0, stallM=0, adelM=0, adesM=0.
- Misaligned, combinational:
  - half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Asserts adelM or adesM; no bus request is issued; stallM=0.
- Store formatting:
  - byte: wdata={4{wd[7:0]}}, wstrb=1<<addr[1:0].
  - half: wdata={2{wd[15:0]}}, wstrb=addr[1] ? 1100 : 0011.
  - word: wdata=wd, wstrb=1111.
  - Loads drive wstrb=0000.
- Load extraction: select the byte or half addressed by addr[1:0], then sign- or zero-extend per lstypeM. The result is registered into readdataM on data_ok.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE:
    - data_req = memenM & ~misaligned.
    - If data_req & addr_ok, go to WAIT.
    - Else if data_req, go to REQ.
    - stallM = data_req.
  - REQ: data_req=1; inputs are stable because the pipeline is frozen. Go to WAIT on addr_ok. stallM=1.
  - WAIT: data_req=0. On data_ok, capture readdataM and go to DONE. stallM=1.
  - DONE: stallM=0; the pipeline advances at this edge unless holdM=1. If holdM, stay in DONE with no reissue and readdataM held. Else go to IDLE.
- Latency: minimum 3 cycles from memenM to the pipeline advancing (req+addr_ok, data_ok, DONE). data_ok never arrives in the same cycle as its own addr_ok.
- data_ok in IDLE or REQ (a stale response after reset) is ignored.
- Reset mid-transaction returns to IDLE immediately; no response is awaited.
- Only one outstanding transaction at a time.

Optional Feature:
- Macro: DSB_PERF_CNT_EN.
- Defined: adds a 32-bit counter perf_stall_cnt (output port) that increments every cycle stallM=1. It saturates at 0xFFFFFFFF and clears on reset.
- Undefined: perf_stall_cnt is tied to 0 and no counter logic exists.

Decomposition:
- Package mem_defs holds:
  - lstype encodings (LS_B, LS_BU, LS_H, LS_HU, LS_W);
  - data_size codes;
  - FSM state encoding (2-bit).
- Sub-module lsu_align (combinational) holds:
  - store replication and wstrb generation;
  - misalignment detection;
  - load byte/half selection and extension.
- The FSM stays in data_sram_bridge.

Test Plan:
- Load byte-signed, addr 0x1003, rdata 0x80FF_FF00, addr_ok in the first cycle, data_ok one cycle later -> readdataM=0xFFFFFF80 in DONE; stallM high for exactly 2 cycles.
- Store half, addr 0x2002, wd 0x1234ABCD, addr_ok delayed 3 cycles -> data_req held 4 cycles; wdata=0xABCDABCD, wstrb=1100, size=1, data_wr=1.
- Load word at addr 0x3001 -> adelM=1, data_req never asserted, stallM=0; store word at 0x3002 -> adesM=1.
- Load half-unsigned completes with holdM=1 for 2 cycles in DONE -> state stays DONE, readdataM stable, no second req; returns to IDLE when holdM drops.
- rst pulled low while in WAIT, then a stray data_ok after release -> outputs return to reset values; the stray data_ok is ignored and readdataM stays 0.
- With DSB_PERF_CNT_EN defined, two back-to-back loads with 2 stall cycles each -> perf_stall_cnt=4.

Source files
------------

// File: rtl/mem_defs.sv
// mem_defs: shared encodings for the data SRAM bridge.
//   - lstype encodings carried down the pipeline with each load/store
//   - data_size codes driven onto the SRAM-like data bus
//   - bridge FSM state encoding
package mem_defs;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_BU = 3'b001;
   localparam logic [2:0] LS_H  = 3'b010;
   localparam logic [2:0] LS_HU = 3'b011;
   localparam logic [2:0] LS_W  = 3'b100;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } bridge_state_t;

   // Unused lstype codes fall through to word so they still get a full
   // alignment check rather than slipping through as a byte access.
   function automatic logic [1:0] ls_size(input logic [2:0] ls);
      case (ls)
         LS_B, LS_BU: ls_size = SZ_BYTE;
         LS_H, LS_HU: ls_size = SZ_HALF;
         default:     ls_size = SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the data SRAM bridge.
//   Ports:
//     lstype     in  3   access type (mem_defs LS_* codes)
//     is_store   in  1   1 = store, 0 = load
//     addr_lo    in  2   low address bits
//     wd         in  32  raw store data
//     rdata      in  32  raw bus read data
//     size       out 2   bus size code
//     misaligned out 1   access not naturally aligned
//     wdata      out 32  store data replicated across lanes
//     wstrb      out 4   byte enables (0000 for loads)
//     load_data  out 32  selected and extended load result
module lsu_align
   import mem_defs::*;
(
   input  logic [2:0]  lstype,
   input  logic        is_store,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wd,
   input  logic [31:0] rdata,
   output logic [1:0]  size,
   output logic        misaligned,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [3:0]  strb_raw;

   always_comb begin
      size       = ls_size(lstype);
      misaligned = 1'b0;
      wdata      = wd;
      strb_raw   = 4'b1111;
      case (size)
         SZ_BYTE: begin
            wdata    = {4{wd[7:0]}};
            strb_raw = 4'b0001 << addr_lo;
         end
         SZ_HALF: begin
            misaligned = addr_lo[0];
            wdata      = {2{wd[15:0]}};
            strb_raw   = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            misaligned = |addr_lo;
            wdata      = wd;
            strb_raw   = 4'b1111;
         end
      endcase
      wstrb = is_store ? strb_raw : 4'b0000;
   end

   always_comb begin
      sel_byte = rdata[7:0];
      case (addr_lo)
         2'd0:    sel_byte = rdata[7:0];
         2'd1:    sel_byte = rdata[15:8];
         2'd2:    sel_byte = rdata[23:16];
         default: sel_byte = rdata[31:24];
      endcase
      sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      load_data = rdata;
      case (lstype)
         LS_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
         LS_BU:   load_data = {24'd0, sel_byte};
         LS_H:    load_data = {{16{sel_half[15]}}, sel_half};
         LS_HU:   load_data = {16'd0, sel_half};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: M-stage load/store unit driving an SRAM-like data bus
// (req / addr_ok / data_ok). One transaction outstanding at a time; stallM
// freezes F/D/E/M while it is in flight.
//   Ports:
//     clk, rst            clock (rising), async active-low reset
//     memenM, memwriteM   M-stage load/store valid, 1 = store
//     lstypeM             access type (mem_defs LS_* codes)
//     aluoutM, writedataM effective address, raw store data
//     holdM               external stall; keeps the result parked in DONE
//     readdataM           extended load result, valid in DONE
//     stallM              freeze request to the hazard unit
//     adelM, adesM        load / store address misaligned
//     data_*              SRAM-like data bus
//     perf_stall_cnt      saturating stall-cycle counter (0 unless enabled)
//   Build option: DSB_PERF_CNT_EN enables perf_stall_cnt.
//
//   state | meaning
//   IDLE  | no transaction; request issued combinationally if memenM
//   REQ   | request held until the bus accepts it (addr_ok)
//   WAIT  | accepted, waiting for data_ok; load result captured then
//   DONE  | result valid, pipeline may advance; parked while holdM
module data_sram_bridge
   import mem_defs::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memenM,
   input  logic              memwriteM,
   input  logic [2:0]        lstypeM,
   input  logic [ADDR_W-1:0] aluoutM,
   input  logic [DATA_W-1:0] writedataM,
   input  logic              holdM,
   output logic [DATA_W-1:0] readdataM,
   output logic              stallM,
   output logic              adelM,
   output logic              adesM,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata,
   output logic [31:0]       perf_stall_cnt
);

   bridge_state_t state;
   bridge_state_t state_nxt;

   logic        misaligned;
   logic [31:0] load_data;

   lsu_align u_align (
      .lstype     (lstypeM),
      .is_store   (memwriteM),
      .addr_lo    (aluoutM[1:0]),
      .wd         (writedataM),
      .rdata      (data_rdata),
      .size       (data_size),
      .misaligned (misaligned),
      .wdata      (data_wdata),
      .wstrb      (data_wstrb),
      .load_data  (load_data)
   );

   assign data_addr = aluoutM;
   assign data_wr   = memwriteM;
   assign adelM     = memenM & ~memwriteM & misaligned;
   assign adesM     = memenM &  memwriteM & misaligned;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      data_req  = 1'b0;
      stallM    = 1'b0;
      case (state)
         ST_IDLE: begin
            data_req = memenM & ~misaligned;
            stallM   = data_req;
            if (data_req && data_addr_ok) begin
               state_nxt = ST_WAIT;
            end else if (data_req) begin
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            data_req = 1'b1;
            stallM   = 1'b1;
            if (data_addr_ok) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stallM = 1'b1;
            if (data_data_ok) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!holdM) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Only a data_ok seen in WAIT belongs to our request; anything earlier
   // is a leftover response from before reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         readdataM <= '0;
      end else if (state == ST_WAIT && data_data_ok) begin
         readdataM <= load_data;
      end
   end

`ifdef DSB_PERF_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stallM && stall_cnt != 32'hFFFF_FFFF) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt;
`else
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;

   logic        clk;
   logic        rst;
   logic        memenM;
   logic        memwriteM;
   logic [2:0]  lstypeM;
   logic [31:0] aluoutM;
   logic [31:0] writedataM;
   logic        holdM;
   logic [31:0] readdataM;
   logic        stallM;
   logic        adelM;
   logic        adesM;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic [31:0] perf_stall_cnt;

`ifdef DSB_PERF_CNT_EN
   localparam logic [31:0] PERF_EXP = 32'd4;
`else
   localparam logic [31:0] PERF_EXP = 32'd0;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   data_sram_bridge dut (
      .clk            (clk),
      .rst            (rst),
      .memenM         (memenM),
      .memwriteM      (memwriteM),
      .lstypeM        (lstypeM),
      .aluoutM        (aluoutM),
      .writedataM     (writedataM),
      .holdM          (holdM),
      .readdataM      (readdataM),
      .stallM         (stallM),
      .adelM          (adelM),
      .adesM          (adesM),
      .data_req       (data_req),
      .data_wr        (data_wr),
      .data_size      (data_size),
      .data_addr      (data_addr),
      .data_wstrb     (data_wstrb),
      .data_wdata     (data_wdata),
      .data_addr_ok   (data_addr_ok),
      .data_data_ok   (data_data_ok),
      .data_rdata     (data_rdata),
      .perf_stall_cnt (perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst          = 1'b0;
      memenM       = 1'b0;
      memwriteM    = 1'b0;
      lstypeM      = 3'b000;
      aluoutM      = 32'h0;
      writedataM   = 32'h0;
      holdM        = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'h0;

      // reset state
      @(negedge clk);
      chk("rst_readdata", readdataM, 32'h0);
      chk("rst_req", 32'(data_req), 32'd0);
      chk("rst_stall", 32'(stallM), 32'd0);
      chk("rst_adel", 32'(adelM), 32'd0);
      chk("rst_ades", 32'(adesM), 32'd0);
      chk("rst_perf", perf_stall_cnt, 32'd0);
      tick();
      rst = 1'b1;
      @(negedge clk);

      // load byte-signed 0x1003, addr_ok at once, data_ok next cycle
      tick();
      memenM = 1'b1; memwriteM = 1'b0; lstypeM = 3'b000; aluoutM = 32'h1003;
      data_addr_ok = 1'b1;
      @(negedge clk);
      chk("lb_req", 32'(data_req), 32'd1);
      chk("lb_stall0", 32'(stallM), 32'd1);
      chk("lb_wr", 32'(data_wr), 32'd0);
      chk("lb_size", 32'(data_size), 32'd0);
      chk("lb_wstrb", 32'(data_wstrb), 32'h0);
      chk("lb_addr", data_addr, 32'h1003);
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h80FF_FF00;
      @(negedge clk);
      chk("lb_wait_req", 32'(data_req), 32'd0);
      chk("lb_stall1", 32'(stallM), 32'd1);
      tick();
      data_data_ok = 1'b0; data_rdata = 32'h0;
      @(negedge clk);
      chk("lb_done_stall", 32'(stallM), 32'd0);
      chk("lb_done_req", 32'(data_req), 32'd0);
      chk("lb_readdata", readdataM, 32'hFFFF_FF80);
      tick();
      memenM = 1'b0;
      @(negedge clk);
      chk("lb_idle_stall", 32'(stallM), 32'd0);

      // store half 0x2002, addr_ok delayed by 3 cycles
      tick();
      memenM = 1'b1; memwriteM = 1'b1; lstypeM = 3'b010; aluoutM = 32'h2002;
      writedataM = 32'h1234_ABCD; data_addr_ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         data_addr_ok = (i == 3);
         @(negedge clk);
         chk($sformatf("sh_req_c%0d", i), 32'(data_req), 32'd1);
         chk($sformatf("sh_stall_c%0d", i), 32'(stallM), 32'd1);
         if (i == 0) begin
            chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
            chk("sh_wstrb", 32'(data_wstrb), 32'hC);
            chk("sh_size", 32'(data_size), 32'd1);
            chk("sh_wr", 32'(data_wr), 32'd1);
         end
      end
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b1;
      @(negedge clk);
      chk("sh_wait_req", 32'(data_req), 32'd0);
      chk("sh_wait_stall", 32'(stallM), 32'd1);
      tick();
      data_data_ok = 1'b0;
      @(negedge clk);
      chk("sh_done_stall", 32'(stallM), 32'd0);
      tick();
      memenM = 1'b0; memwriteM = 1'b0;

      // misaligned word load / store
      lstypeM = 3'b100; aluoutM = 32'h3001; memenM = 1'b1;
      @(negedge clk);
      chk("lw_mis_adel", 32'(adelM), 32'd1);
      chk("lw_mis_ades", 32'(adesM), 32'd0);
      chk("lw_mis_req", 32'(data_req), 32'd0);
      chk("lw_mis_stall", 32'(stallM), 32'd0);
      tick();
      @(negedge clk);
      chk("lw_mis_req2", 32'(data_req), 32'd0);
      tick();
      memwriteM = 1'b1; aluoutM = 32'h3002;
      @(negedge clk);
      chk("sw_mis_ades", 32'(adesM), 32'd1);
      chk("sw_mis_adel", 32'(adelM), 32'd0);
      chk("sw_mis_req", 32'(data_req), 32'd0);
      chk("sw_mis_stall", 32'(stallM), 32'd0);

      // combinational store-format probes with no access in flight
      tick();
      memenM = 1'b0; memwriteM = 1'b1; lstypeM = 3'b000;
      aluoutM = 32'h1001; writedataM = 32'h0000_005A;
      @(negedge clk);
      chk("sb_wdata", data_wdata, 32'h5A5A_5A5A);
      chk("sb_wstrb", 32'(data_wstrb), 32'h2);
      chk("sb_size", 32'(data_size), 32'd0);
      chk("probe_req", 32'(data_req), 32'd0);
      tick();
      lstypeM = 3'b100; aluoutM = 32'h1000; writedataM = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("sw_wdata", data_wdata, 32'hDEAD_BEEF);
      chk("sw_wstrb", 32'(data_wstrb), 32'hF);
      chk("sw_size", 32'(data_size), 32'd2);
      tick();
      lstypeM = 3'b010; writedataM = 32'h0000_BEEF;
      @(negedge clk);
      chk("sh_lo_wdata", data_wdata, 32'hBEEF_BEEF);
      chk("sh_lo_wstrb", 32'(data_wstrb), 32'h3);
      tick();
      memwriteM = 1'b0;
      @(negedge clk);
      chk("ld_wstrb", 32'(data_wstrb), 32'h0);

      // load half-unsigned 0x4002 parked in DONE by holdM
      tick();
      memenM = 1'b1; memwriteM = 1'b0; lstypeM = 3'b011; aluoutM = 32'h4002;
      data_addr_ok = 1'b1;
      @(negedge clk);
      chk("lhu_req", 32'(data_req), 32'd1);
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBEEF_1234;
      @(negedge clk);
      chk("lhu_wait_stall", 32'(stallM), 32'd1);
      tick();
      data_data_ok = 1'b0; data_rdata = 32'h1111_1111; holdM = 1'b1;
      @(negedge clk);
      chk("lhu_hold1_stall", 32'(stallM), 32'd0);
      chk("lhu_hold1_req", 32'(data_req), 32'd0);
      chk("lhu_hold1_rd", readdataM, 32'h0000_BEEF);
      tick();
      @(negedge clk);
      chk("lhu_hold2_stall", 32'(stallM), 32'd0);
      chk("lhu_hold2_req", 32'(data_req), 32'd0);
      chk("lhu_hold2_rd", readdataM, 32'h0000_BEEF);
      tick();
      holdM = 1'b0;
      @(negedge clk);
      chk("lhu_release_req", 32'(data_req), 32'd0);
      chk("lhu_release_rd", readdataM, 32'h0000_BEEF);

      // next instruction follows straight away: proves return to IDLE,
      // then reset lands while it waits for data_ok
      tick();
      lstypeM = 3'b001; aluoutM = 32'h5000; data_addr_ok = 1'b1; data_rdata = 32'h0;
      @(negedge clk);
      chk("idle_after_hold_req", 32'(data_req), 32'd1);
      tick();
      data_addr_ok = 1'b0;
      @(negedge clk);
      chk("midrst_wait_stall", 32'(stallM), 32'd1);
      #2;
      rst = 1'b0; memenM = 1'b0;
      #1;
      chk("midrst_stall", 32'(stallM), 32'd0);
      chk("midrst_req", 32'(data_req), 32'd0);
      chk("midrst_readdata", readdataM, 32'h0);
      chk("midrst_perf", perf_stall_cnt, 32'd0);
      tick();
      tick();
      rst = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("stray_stall", 32'(stallM), 32'd0);
      chk("stray_req", 32'(data_req), 32'd0);
      tick();
      data_data_ok = 1'b0; data_rdata = 32'h0;
      @(negedge clk);
      chk("stray_readdata", readdataM, 32'h0);
      chk("stray_stall2", 32'(stallM), 32'd0);

      // two back-to-back loads, two stall cycles each
      tick();
      memenM = 1'b1; memwriteM = 1'b0; lstypeM = 3'b100; aluoutM = 32'h6000;
      data_addr_ok = 1'b1;
      @(negedge clk);
      chk("b2b0_req", 32'(data_req), 32'd1);
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("b2b0_stall", 32'(stallM), 32'd1);
      tick();
      data_data_ok = 1'b0;
      @(negedge clk);
      chk("b2b0_readdata", readdataM, 32'hCAFE_F00D);
      tick();
      lstypeM = 3'b000; aluoutM = 32'h6001; data_addr_ok = 1'b1;
      @(negedge clk);
      chk("b2b1_req", 32'(data_req), 32'd1);
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_7F00;
      @(negedge clk);
      chk("b2b1_stall", 32'(stallM), 32'd1);
      tick();
      data_data_ok = 1'b0;
      @(negedge clk);
      chk("b2b1_readdata", readdataM, 32'h0000_007F);
      tick();
      memenM = 1'b0;
      @(negedge clk);
      chk("perf_cnt", perf_stall_cnt, PERF_EXP);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
